wb_regfile: RTL

Writeback stage and architectural register file for the 5-stage pipelined RV32I core. It consumes the MEM/WB pipeline-register outputs and selects the writeback result from ALU, load data or PC+4. It commits that result to the 32x32 register file and serves the two decode-stage read ports, with same-cycle write-through bypass. It also exports the selected result for the forwarding network and keeps a committed-write counter for debug and performance use.

---
 rtl/wb_regfile.sv | 58 +++++
 1 files changed

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, 32x32 register file with write-through
// read bypass, and a committed-write counter for debug/performance.
module wb_regfile #(
  parameter int DEPTH = 32,
  parameter int XLEN  = 32,
  parameter int CNTW  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteW,
  input  logic [1:0]               ResultSrcW,
  input  logic [XLEN-1:0]          ALUResultW,
  input  logic [XLEN-1:0]          ReadDataW,
  input  logic [XLEN-1:0]          PCPlus4W,
  input  logic [$clog2(DEPTH)-1:0] RdW,
  input  logic [$clog2(DEPTH)-1:0] A1,
  input  logic [$clog2(DEPTH)-1:0] A2,
  output logic [XLEN-1:0]          RD1,
  output logic [XLEN-1:0]          RD2,
  output logic [XLEN-1:0]          ResultW,
  output logic [CNTW-1:0]          WbCountW
);

  logic [XLEN-1:0] regs [DEPTH];
  logic            commit;

  // Encoding 11 is reserved and falls back to the ALU result so it never yields X.
  always_comb begin
    case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  // Reset wins over a same-cycle commit, and x0 is never a write target.
  assign commit = RegWriteW && (RdW != '0) && !rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the whole array is cleared in reset because
  // software relies on architectural registers reading 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      WbCountW <= '0;
    end else if (commit) begin
      regs[RdW] <= ResultW;
      WbCountW  <= WbCountW + CNTW'(1);
    end
  end

  // Write-through bypass lets decode see the writeback value in the same cycle.
  assign RD1 = (A1 == '0)                ? '0      :
               (commit && (RdW == A1))   ? ResultW : regs[A1];
  assign RD2 = (A2 == '0)                ? '0      :
               (commit && (RdW == A2))   ? ResultW : regs[A2];

endmodule
